// File: rtl/botoes_debouncer_eventos.sv
// Debouncer bank for N push-buttons with registered press/release pulses and a
// single-entry press event register. Optional auto-repeat: BOTOES_AUTO_REPEAT_EN.
module botoes_debouncer_eventos #(
  parameter int N             = 13,
  parameter int DEBOUNCE_TIME = 1000,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  localparam int IW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  botoes,
  output logic [N-1:0]  botoes_debounced,
  output logic [N-1:0]  botoes_press,
  output logic [N-1:0]  botoes_release,
  output logic          algum_pressionado,
  output logic          evento_valid,
  output logic [IW-1:0] evento_idx,
  input  logic          evento_ack,
  output logic          evento_perdido
);

  localparam int CW = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TIME - 1);
  localparam logic [N-1:0] INV = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [N-1:0]  sync1, sync2, stable, toggle, press_q, release_q;
  logic [CW-1:0] cnt [N];
  logic [N-1:0]  ev_p;
  logic [IW-1:0] low_idx;
  logic          ev_any, ev_multi, ev_free, ev_lost;

  // A channel flips once its synchronised level has disagreed with the stable
  // level for DEBOUNCE_TIME consecutive edges.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < N; i++) begin
      toggle[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1     <= botoes ^ INV;
      sync2     <= sync1;
      stable    <= stable ^ toggle;
      press_q   <= toggle & ~stable;
      release_q <= toggle & stable;
      for (int i = 0; i < N; i++) begin
        if ((sync2[i] == stable[i]) || toggle[i]) cnt[i] <= '0;
        else                                      cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  assign botoes_debounced  = stable;
  assign botoes_press      = press_q;
  assign botoes_release    = release_q;
  assign algum_pressionado = |stable;

`ifdef BOTOES_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [IW-1:0] held_idx, low_press;
  logic [RW-1:0] rep_cnt;
  logic          rep_first, held_on, rep_fire;
  logic [N-1:0]  inject;

  always_comb begin
    low_press = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press_q[i]) low_press = IW'(i);
    end
  end

  assign held_on  = stable[held_idx];
  // First repeat after REPEAT_DELAY cycles, later ones every REPEAT_PERIOD.
  assign rep_fire = held_on && !(|press_q) &&
                    (rep_cnt == (rep_first ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
  assign inject   = rep_fire ? (N'(1) << held_idx) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_idx  <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (|press_q) begin
      held_idx  <= low_press;
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (!held_on) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end

  assign ev_p = press_q | inject;
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign ev_p = press_q;
`endif

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ev_p[i]) low_idx = IW'(i);
    end
  end

  // Handshake: an event is offered while evento_valid=1 and is consumed on any
  // edge where evento_ack=1; ack with evento_valid=0 has no effect. A press
  // arriving with the register occupied and unacked is dropped and flagged.
  assign ev_any   = |ev_p;
  assign ev_multi = |(ev_p & (ev_p - N'(1)));
  assign ev_free  = !evento_valid || evento_ack;
  assign ev_lost  = (ev_any && !ev_free) || ev_multi;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evento_valid   <= 1'b0;
      evento_idx     <= '0;
      evento_perdido <= 1'b0;
    end else begin
      if (ev_any && ev_free) begin
        evento_idx   <= low_idx;
        evento_valid <= 1'b1;
      end else if (!ev_any && evento_ack) begin
        evento_valid <= 1'b0;
      end
      if (ev_lost)                        evento_perdido <= 1'b1;
      else if (evento_valid && evento_ack) evento_perdido <= 1'b0;
    end
  end

endmodule
